// File: rtl/irq_ctl.sv
// Interrupt front-end: one edge-sensitive NMI plus CHANNELS maskable IRQs with fixed priority,
// per-source vectors, a registered take request and a vector lock held until the core reads it.
module irq_ctl #(
    parameter int unsigned CHANNELS  = 8,
    parameter logic [7:0]  EDGE_MASK = 8'h00,
    parameter bit          VECTORED  = 1'b1,
    parameter logic [7:0]  VEC_BASE  = 8'hE0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rdy,
    input  logic                sync,
    input  logic                I,
    input  logic                nmi,
    input  logic [CHANNELS-1:0] irq,
    input  logic [CHANNELS-1:0] irq_en,
    input  logic                vec_ack,
    output logic                take,
    output logic [7:0]          int_vec,
    output logic                int_nmi,
    output logic [2:0]          int_src,
    output logic [CHANNELS-1:0] pend
);

    localparam int unsigned VEC_TOP = 32'(VEC_BASE) + 2 * (CHANNELS - 1);
    localparam logic [CHANNELS-1:0] EDGE = EDGE_MASK[CHANNELS-1:0];

    generate
        if (CHANNELS < 1 || CHANNELS > 8 || VEC_TOP > 255) begin : g_bad_param
            $error("irq_ctl: CHANNELS must be 1..8 and the last channel vector must not wrap");
        end
    endgenerate

    typedef enum logic {
        IDLE,
        SERVICE
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic                prev_nmi;
    logic [CHANNELS-1:0] prev_irq;
    logic                nmi_pend;
    logic                nmi_pend_d;
    logic [CHANNELS-1:0] edge_pend;
    logic [CHANNELS-1:0] edge_pend_d;
    logic [CHANNELS-1:0] edge_clr;
    logic [CHANNELS-1:0] req;
    logic                irq_hit;
    logic [2:0]          irq_idx;
    logic                hit;
    logic [7:0]          arb_vec;
    logic                capture;
    logic                take_d;

    // Edge channels report their latch, level channels report the live input.
    assign pend = (edge_pend & EDGE) | (irq & ~EDGE);
    assign req  = pend & irq_en & {CHANNELS{~I}};

    // Fixed priority: lowest enabled pending channel wins.
    always_comb begin
        irq_hit = 1'b0;
        irq_idx = 3'd0;
        for (int k = 0; k < int'(CHANNELS); k++) begin
            if (!irq_hit && req[k]) begin
                irq_hit = 1'b1;
                irq_idx = 3'(k);
            end
        end
    end

    assign hit = nmi_pend | irq_hit;

    always_comb begin
        arb_vec = 8'hFE;
        if (nmi_pend) begin
            arb_vec = 8'hFA;
        end else if (VECTORED) begin
            arb_vec = VEC_BASE + {4'b0000, irq_idx, 1'b0};
        end
    end

    // Next state, capture strobe and latch updates; a new edge beats a same-cycle clear.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (sync && rdy && take && hit) begin
                    state_d = SERVICE;
                    capture = 1'b1;
                end
            end
            SERVICE: begin
                if (vec_ack && rdy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        for (int k = 0; k < int'(CHANNELS); k++) begin
            edge_clr[k] = capture && !nmi_pend && (irq_idx == 3'(k)) && EDGE[k];
        end

        nmi_pend_d  = (nmi & ~prev_nmi) | (nmi_pend & ~(capture & nmi_pend));
        edge_pend_d = ((irq & ~prev_irq) | (edge_pend & ~edge_clr)) & EDGE;
        take_d      = (state_d == IDLE) && hit;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            prev_nmi  <= 1'b0;
            prev_irq  <= '0;
            nmi_pend  <= 1'b0;
            edge_pend <= '0;
            take      <= 1'b0;
            int_vec   <= 8'hFE;
            int_nmi   <= 1'b0;
            int_src   <= 3'd0;
        end else begin
            state_q   <= state_d;
            prev_nmi  <= nmi;
            prev_irq  <= irq;
            nmi_pend  <= nmi_pend_d;
            edge_pend <= edge_pend_d;
            take      <= take_d;
            if (capture) begin
                int_vec <= arb_vec;
                int_nmi <= nmi_pend;
                int_src <= irq_idx;
            end
        end
    end

endmodule

// File: tb/tb_irq_ctl.sv
// Scoreboard bench for irq_ctl: a behavioural model predicts every cycle, a monitor compares
// a vectored instance and a legacy (VECTORED=0) instance driven by the same stimulus.
module tb_irq_ctl;

    localparam logic [7:0] EDGE = 8'h4C;

    logic       clk = 1'b0;
    logic       reset, rdy, sync, I, nmi, vec_ack;
    logic [7:0] irq, irq_en;
    logic       take, int_nmi, take_l, int_nmi_l;
    logic [7:0] int_vec, int_vec_l, pend, pend_l;
    logic [2:0] int_src, int_src_l;

    always #5 clk = ~clk;

    irq_ctl #(.CHANNELS(8), .EDGE_MASK(EDGE), .VECTORED(1'b1), .VEC_BASE(8'hE0)) u_dut (
        .clk(clk), .reset(reset), .rdy(rdy), .sync(sync), .I(I), .nmi(nmi), .irq(irq),
        .irq_en(irq_en), .vec_ack(vec_ack), .take(take), .int_vec(int_vec),
        .int_nmi(int_nmi), .int_src(int_src), .pend(pend)
    );

    irq_ctl #(.CHANNELS(8), .EDGE_MASK(EDGE), .VECTORED(1'b0), .VEC_BASE(8'hE0)) u_legacy (
        .clk(clk), .reset(reset), .rdy(rdy), .sync(sync), .I(I), .nmi(nmi), .irq(irq),
        .irq_en(irq_en), .vec_ack(vec_ack), .take(take_l), .int_vec(int_vec_l),
        .int_nmi(int_nmi_l), .int_src(int_src_l), .pend(pend_l)
    );

    typedef struct {
        logic       take;
        logic       nmi;
        logic [2:0] src;
        logic [7:0] vec;
        logic [7:0] vec_l;
        logic [7:0] pend;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model: what the controller holds after the coming clock edge.
    bit       m_nmi_latch, m_prev_nmi, m_svc, m_take, m_nmi;
    bit [7:0] m_latch, m_prev_irq, m_vec, m_vec_l;
    int       m_src;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic void model_reset();
        m_nmi_latch = 0; m_prev_nmi = 0; m_svc = 0; m_take = 0; m_nmi = 0;
        m_latch = 0; m_prev_irq = 0; m_vec = 8'hFE; m_vec_l = 8'hFE; m_src = 0;
    endfunction

    function automatic void model_step();
        int       sel;
        bit       sel_nmi, hit, cap, leave;
        bit [7:0] live;
        exp_t     e;
        if (reset) begin
            model_reset();
        end else begin
            sel = -1;
            for (int k = 0; k < 8; k++) live[k] = EDGE[k] ? m_latch[k] : irq[k];
            sel_nmi = m_nmi_latch;
            if (!sel_nmi && !I) begin
                for (int k = 7; k >= 0; k--) if (live[k] && irq_en[k]) sel = k;
            end
            hit   = sel_nmi || (sel >= 0);
            cap   = !m_svc && sync && rdy && m_take && hit;
            leave = m_svc && vec_ack && rdy;
            m_nmi_latch = (nmi && !m_prev_nmi) || (m_nmi_latch && !(cap && sel_nmi));
            for (int k = 0; k < 8; k++) begin
                if (EDGE[k])
                    m_latch[k] = (irq[k] && !m_prev_irq[k]) || (m_latch[k] && !(cap && !sel_nmi && sel == k));
            end
            m_prev_nmi = nmi;
            m_prev_irq = irq;
            if (cap) begin
                m_svc = 1;
                m_nmi = sel_nmi;
                if (sel_nmi) begin
                    m_vec = 8'hFA; m_vec_l = 8'hFA;
                end else begin
                    m_src = sel; m_vec = 8'(224 + 2 * sel); m_vec_l = 8'hFE;
                end
            end else if (leave) begin
                m_svc = 0;
            end
            m_take = !m_svc && hit;
        end
        e.take = m_take; e.nmi = m_nmi; e.src = 3'(m_src); e.vec = m_vec; e.vec_l = m_vec_l;
        for (int k = 0; k < 8; k++) e.pend[k] = EDGE[k] ? m_latch[k] : irq[k];
        exp_q.push_back(e);
    endfunction

    // Inputs are already set; predict the coming edge and wait for the next falling edge.
    task automatic tick();
        model_step();
        @(negedge clk);
    endtask

    task automatic sync_pulse();
        sync = 1; tick(); sync = 0;
    endtask

    task automatic ack();
        vec_ack = 1; tick(); vec_ack = 0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("take", 8'(take), 8'(e.take));
                chk("int_nmi", 8'(int_nmi), 8'(e.nmi));
                chk("int_vec", int_vec, e.vec);
                chk("int_vec_legacy", int_vec_l, e.vec_l);
                chk("int_nmi_legacy", 8'(int_nmi_l), 8'(e.nmi));
                if (!e.nmi) chk("int_src", 8'(int_src), 8'(e.src));
                chk("pend", pend, e.pend);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: bench did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        reset = 1; rdy = 1; sync = 0; I = 0; nmi = 0; vec_ack = 0; irq = 0; irq_en = 8'hFF;
        model_reset();
        @(negedge clk);
        tick();
        chk("reset_take", 8'(take), 8'h00);
        chk("reset_vec", int_vec, 8'hFE);
        tick();
        reset = 0;

        // NMI latency and single service while held high
        nmi = 1; tick();
        chk("nmi_take_t0", 8'(take), 8'h00);
        tick();
        chk("nmi_take_t1", 8'(take), 8'h01);
        sync_pulse();
        chk("nmi_vec", int_vec, 8'hFA);
        chk("nmi_flag", 8'(int_nmi), 8'h01);
        ack();
        for (int i = 0; i < 20; i++) begin
            sync = (i % 3 == 0); vec_ack = (i % 3 == 1); tick();
        end
        sync = 0; vec_ack = 0;
        chk("nmi_held_once", 8'(take), 8'h00);
        nmi = 0; tick();

        // Edge ch2 and level ch5 together: ch2 first, then ch5
        irq[5] = 1; irq[2] = 1; tick(); tick();
        sync_pulse();
        chk("ch2_vec", int_vec, 8'hE4);
        chk("ch2_src", 8'(int_src), 8'h02);
        ack();
        sync_pulse();
        chk("ch5_vec", int_vec, 8'hEA);
        ack();
        chk("ch5_still_level", 8'(take), 8'h01);
        irq[5] = 0; tick();
        chk("level_drop", 8'(take), 8'h00);
        irq[2] = 0; tick();

        // Masked edge channel fires once unmasked
        I = 1; irq[3] = 1;
        repeat (50) tick();
        chk("masked_take", 8'(take), 8'h00);
        I = 0; tick();
        chk("unmask_take", 8'(take), 8'h01);
        sync_pulse();
        chk("ch3_src", 8'(int_src), 8'h03);
        chk("ch3_vec", int_vec, 8'hE6);
        ack();
        irq[3] = 0; tick();

        // NMI and IRQ0 together: NMI first; legacy vectors
        nmi = 1; irq[0] = 1; tick(); tick();
        sync_pulse();
        chk("both_legacy_vec", int_vec_l, 8'hFA);
        ack();
        sync_pulse();
        chk("irq0_legacy_vec", int_vec_l, 8'hFE);
        chk("irq0_vec", int_vec, 8'hE0);
        ack();
        irq[0] = 0; nmi = 0; tick();

        // NMI edge during a stalled SERVICE re-pends; vec_ack in IDLE is ignored
        nmi = 1; tick(); tick();
        sync_pulse();
        nmi = 0; tick();
        nmi = 1; rdy = 0; vec_ack = 1; tick();
        rdy = 1; tick();
        vec_ack = 0;
        chk("nmi_repend", 8'(take), 8'h01);
        sync_pulse();
        chk("nmi_second", 8'(int_nmi), 8'h01);
        ack();
        vec_ack = 1; repeat (3) tick(); vec_ack = 0;
        chk("idle_ack_ignored", 8'(take), 8'h00);
        nmi = 0; tick();

        // Asynchronous reset in the middle of a SERVICE
        nmi = 1; tick(); tick();
        sync_pulse();
        nmi = 0;
        #2;
        reset = 1;
        #1;
        chk("async_rst_take", 8'(take), 8'h00);
        chk("async_rst_vec", int_vec, 8'hFE);
        chk("async_rst_pend", pend, 8'h00);
        tick();
        reset = 0;
        repeat (4) tick();
        chk("post_rst_take", 8'(take), 8'h00);

        // Randomised traffic
        for (int n = 0; n < 3000; n++) begin
            reset   = ($urandom_range(0, 199) == 0);
            rdy     = ($urandom_range(0, 9) < 8);
            sync    = ($urandom_range(0, 2) == 0);
            vec_ack = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 19) == 0) I = ~I;
            if ($urandom_range(0, 15) == 0) nmi = ~nmi;
            if ($urandom_range(0, 31) == 0) irq_en = 8'($urandom);
            irq = irq ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            tick();
        end
        reset = 0;
        @(posedge clk);
        #2;
        chk("queue_drained", 8'(exp_q.size()), 8'h00);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
